keypad_entry: RTL and testbench

//  Input side of the board front panel, the counterpart to the multiplexed 7-seg output driver.
//  - Scans a 4x4 active-low key matrix and debounces each press.
//  - Accumulates up to 4 decimal digits plus a sign.
//  - On ENTER, converts the entry to a 32-bit two's-complement value for the MIPS core (I/O input register).
//  - Exposes the live BCD entry so the display can echo it.

---
 rtl/keypad_entry_pkg.sv | 24 ++
 rtl/keypad_entry_key_scan.sv | 85 ++++++++
 rtl/keypad_entry.sv | 83 ++++++++
 tb/tb_keypad_entry.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_entry_pkg.sv
// Shared definitions for the front-panel keypad: key codes, scan FSM states
// and the BCD-to-binary helper used on ENTER.
package keypad_entry_pkg;

  localparam logic [3:0] KEY_SIGN = 4'd10;
  localparam logic [3:0] KEY_CLR  = 4'd11;
  localparam logic [3:0] KEY_BS   = 4'd12;
  localparam logic [3:0] KEY_ENT  = 4'd13;

  localparam logic [2:0] MAX_DIGITS = 3'd4;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } scan_state_t;

  // Four BCD digits, [15:12] most significant; result never exceeds 9999.
  function automatic logic [13:0] bcd_to_bin(input logic [15:0] bcd);
    return 14'(bcd[15:12]) * 14'd1000 + 14'(bcd[11:8]) * 14'd100 +
           14'(bcd[7:4]) * 14'd10 + 14'(bcd[3:0]);
  endfunction

endpackage

// File: rtl/keypad_entry_key_scan.sv
// 4x4 active-low matrix scanner: row synchronizer, column rotation and a
// press/release debounce FSM producing one key_stb per physical press.
module key_scan
  import keypad_entry_pkg::*;
#(
  parameter int unsigned SCAN_BITS = 16,
  parameter int unsigned DEB_W     = 20,
  parameter int unsigned DEB_MAX   = 1000000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic       key_stb,
  output logic [3:0] key_code
);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_MAX - 1);

  scan_state_t          state, state_next;
  logic [3:0]           row_meta, row_sync;
  logic [SCAN_BITS-1:0] scan_cnt;
  logic [DEB_W-1:0]     deb_cnt;
  logic [1:0]           col_idx, row_lat, low_idx;
  logic                 any_low;

  always_comb begin
    any_low = ~&row_sync;
    low_idx = 2'd3;
    if (!row_sync[2]) low_idx = 2'd2;
    if (!row_sync[1]) low_idx = 2'd1;
    if (!row_sync[0]) low_idx = 2'd0;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= SCAN;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      SCAN:     if (any_low) state_next = DEBOUNCE;
      DEBOUNCE: begin
        if (row_sync[row_lat])       state_next = SCAN;
        else if (deb_cnt == DEB_LAST) state_next = HELD;
      end
      HELD:     if (!any_low && deb_cnt == DEB_LAST) state_next = SCAN;
      default:  state_next = SCAN;
    endcase
  end

  always_comb begin
    key_stb  = (state == DEBOUNCE) && !row_sync[row_lat] && (deb_cnt == DEB_LAST);
    key_code = {row_lat, col_idx};
    key_col  = ~(4'b0001 << col_idx);
  end

  // Column index stays frozen outside SCAN, so it doubles as the latched column.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      row_meta <= '1;
      row_sync <= '1;
      scan_cnt <= '0;
      col_idx  <= '0;
      row_lat  <= '0;
      deb_cnt  <= '0;
    end else begin
      row_meta <= key_row;
      row_sync <= row_meta;
      if (state == SCAN) begin
        if (any_low) begin
          row_lat <= low_idx;
        end else begin
          scan_cnt <= scan_cnt + 1'b1;
          if (&scan_cnt) col_idx <= col_idx + 1'b1;
        end
      end
      if (state != state_next || state == SCAN) deb_cnt <= '0;
      else if (state == HELD && any_low)        deb_cnt <= '0;
      else                                      deb_cnt <= deb_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry front end: scans keys, accumulates a signed 4-digit BCD entry
// and converts it to a 32-bit two's-complement value on ENTER.
module keypad_entry
  import keypad_entry_pkg::*;
#(
  parameter int unsigned SCAN_BITS = 16,
  parameter int unsigned DEB_W     = 20,
  parameter int unsigned DEB_MAX   = 1000000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [3:0]  key_row,
  output logic [3:0]  key_col,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic [15:0] entry_bcd,
  output logic        entry_neg,
  output logic [2:0]  digit_cnt
);

  logic        key_stb;
  logic [3:0]  key_code;
  logic [31:0] mag32;

  key_scan #(
    .SCAN_BITS (SCAN_BITS),
    .DEB_W     (DEB_W),
    .DEB_MAX   (DEB_MAX)
  ) u_scan (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_row   (key_row),
    .key_col   (key_col),
    .key_stb   (key_stb),
    .key_code  (key_code)
  );

  always_comb mag32 = {18'd0, bcd_to_bin(entry_bcd)};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      entry_bcd  <= '0;
      entry_neg  <= 1'b0;
      digit_cnt  <= '0;
    end else begin
      data_valid <= 1'b0;
      if (key_stb) begin
        if (key_code <= 4'd9) begin
          if (digit_cnt < MAX_DIGITS) begin
            entry_bcd <= {entry_bcd[11:0], key_code};
            digit_cnt <= digit_cnt + 1'b1;
          end
        end else begin
          case (key_code)
            KEY_SIGN: entry_neg <= ~entry_neg;
            KEY_CLR: begin
              entry_bcd <= '0;
              entry_neg <= 1'b0;
              digit_cnt <= '0;
            end
            KEY_BS: begin
              if (digit_cnt != 3'd0) begin
                entry_bcd <= entry_bcd >> 4;
                digit_cnt <= digit_cnt - 1'b1;
              end
            end
            KEY_ENT: begin
              data_out   <= entry_neg ? -mag32 : mag32;
              data_valid <= 1'b1;
              entry_bcd  <= '0;
              entry_neg  <= 1'b0;
              digit_cnt  <= '0;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Randomized keypad bench: a matrix model drives key_row from key_col and a
// queue-based entry model predicts the BCD entry and the ENTER results.
module tb_keypad_entry;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [3:0]  key_row, key_col;
  logic [31:0] data_out;
  logic        data_valid;
  logic [15:0] entry_bcd;
  logic        entry_neg;
  logic [2:0]  digit_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;
  int vrun     = 0;

  logic       press_en = 1'b0;
  logic [3:0] press_code = 4'd0;

  int          digits[$];
  bit          neg = 1'b0;
  logic [31:0] last_out = '0;
  int          exp_valid = 0;

  always #5 sys_clk = ~sys_clk;

  keypad_entry #(
    .SCAN_BITS (2),
    .DEB_W     (8),
    .DEB_MAX   (4)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .key_row    (key_row),
    .key_col    (key_col),
    .data_out   (data_out),
    .data_valid (data_valid),
    .entry_bcd  (entry_bcd),
    .entry_neg  (entry_neg),
    .digit_cnt  (digit_cnt)
  );

  // Pressed switch connects its row to its column line.
  always_comb begin
    key_row = '1;
    if (press_en && !key_col[press_code[1:0]]) key_row[press_code[3:2]] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (sys_rst_n === 1'b1) begin
      if (data_valid) begin
        vrun++;
        if (vrun == 1) n_valid++;
      end else begin
        if (vrun != 0) check("dv_width", vrun, 1);
        vrun = 0;
      end
    end
  end

  function automatic logic [15:0] model_bcd();
    logic [15:0] r = '0;
    foreach (digits[i]) r = (r << 4) | 16'(digits[i]);
    return r;
  endfunction

  task automatic model_apply(input int code);
    int m = 0;
    logic [31:0] v;
    exp_valid = 0;
    if (code <= 9) begin
      if (digits.size() < 4) digits.push_back(code);
    end else if (code == 10) neg = !neg;
    else if (code == 11) begin
      digits.delete(); neg = 1'b0;
    end else if (code == 12) begin
      if (digits.size() > 0) void'(digits.pop_back());
    end else if (code == 13) begin
      foreach (digits[i]) m = m * 10 + digits[i];
      v = 32'(m);
      last_out = neg ? -v : v;
      digits.delete(); neg = 1'b0;
      exp_valid = 1;
    end
  endtask

  task automatic check_entry(input string tag);
    check({tag, "_bcd"}, 32'(entry_bcd), 32'(model_bcd()));
    check({tag, "_neg"}, 32'(entry_neg), 32'(neg));
    check({tag, "_cnt"}, 32'(digit_cnt), 32'(digits.size()));
    check({tag, "_out"}, data_out, last_out);
  endtask

  task automatic press(input int code, input int hold);
    int v0 = n_valid;
    @(negedge sys_clk);
    press_code = 4'(code);
    press_en = 1'b1;
    repeat (hold) @(negedge sys_clk);
    press_en = 1'b0;
    repeat (30) @(negedge sys_clk);
    model_apply(code);
    check("valid_pulses", n_valid - v0, exp_valid);
    check_entry("press");
  endtask

  task automatic bounce(input int code);
    int v0 = n_valid;
    bit found = 1'b0;
    press_code = 4'(code);
    for (int i = 0; i < 200; i++) begin
      @(negedge sys_clk);
      if (!key_col[press_code[1:0]]) begin
        found = 1'b1;
        break;
      end
    end
    check("bounce_col_seen", 32'(found), 1);
    press_en = 1'b1;
    repeat (2) @(negedge sys_clk);
    press_en = 1'b0;
    repeat (30) @(negedge sys_clk);
    check("bounce_valid", n_valid - v0, 0);
    check_entry("bounce");
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst_col", 32'(key_col), 32'hE);
    check("rst_out", data_out, 0);
    check("rst_dv", 32'(data_valid), 0);
    check_entry("rst");

    // Press digit 0 (row0/col0) and reset while it is being debounced.
    sys_rst_n = 1'b1;
    press_code = 4'd0;
    press_en = 1'b1;
    repeat (4) @(posedge sys_clk);
    #1 sys_rst_n = 1'b0;
    @(negedge sys_clk);
    check("midrst_col", 32'(key_col), 32'hE);
    check("midrst_bcd", 32'(entry_bcd), 0);
    check("midrst_cnt", 32'(digit_cnt), 0);
    repeat (2) @(negedge sys_clk);
    press_en = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (40) @(negedge sys_clk);
    check("midrst_valid", n_valid, 0);
    check_entry("midrst_after");

    press(1, 70); press(2, 70); press(3, 70); press(4, 70);
    check("bcd_1234", 32'(entry_bcd), 32'h1234);
    press(13, 70);
    check("out_1234", data_out, 32'd1234);

    press(10, 70); press(5, 70); press(0, 70); press(13, 70);
    check("out_m50", data_out, 32'hFFFF_FFCE);

    press(9, 70); press(8, 70); press(7, 70); press(6, 70); press(5, 70);
    check("bcd_9876", 32'(entry_bcd), 32'h9876);
    press(12, 70);
    check("bcd_0987", 32'(entry_bcd), 32'h0987);

    bounce(7);
    press(3, 1000);

    press(11, 70);
    press(10, 70); press(13, 70);
    check("out_negzero", data_out, 0);

    press(4, 70); press(10, 70); press(11, 70);
    check("clr_bcd", 32'(entry_bcd), 0);

    for (int n = 0; n < 40; n++) begin
      int r = int'($urandom_range(0, 21));
      press(r > 15 ? r - 16 : r, int'($urandom_range(60, 150)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
